// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates one single-beat SRAM/IO bus between the core data port, the
//   core instruction-fetch port and an external DMA requester. Priority is
//   data > fetch > DMA. DMA is forced to win once it has watched DMA_STARVE
//   consecutive core grants while waiting. Each access runs IDLE -> BUSY -> DONE,
//   so there are at least three cycles per beat.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   ifetch, pc, idone               fetch request, halfword address, done pulse
//   addr, rstrobe, wmask, wdata,    data port request, address and payload
//   io_access, rdone, wdone         data port IO select and done pulses
//   dma_req, dma_we, dma_addr,      DMA request, direction, address and payload
//   dma_wdata, dma_wmask, dma_done  DMA done pulse
//   rdata                           last read data, shared by all requesters
//   m_req, m_we, m_addr, m_wdata,   bus beat, held stable until m_ack
//   m_wmask, m_io, m_ack, m_rdata
//   owner                           0 none, 1 data, 2 fetch, 3 DMA
module mem_bus_arbiter #(
    parameter int RV         = 32,
    parameter int VA         = RV,
    parameter int DMA_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifetch,
    input  logic [VA-2:0]         pc,
    output logic                  idone,
    input  logic [VA-RV/16-1:0]   addr,
    input  logic [1:0]            rstrobe,
    input  logic [RV/8-1:0]       wmask,
    input  logic [RV-1:0]         wdata,
    input  logic                  io_access,
    output logic                  rdone,
    output logic                  wdone,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [VA-RV/16-1:0]   dma_addr,
    input  logic [RV-1:0]         dma_wdata,
    input  logic [RV/8-1:0]       dma_wmask,
    output logic                  dma_done,
    output logic [RV-1:0]         rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [VA-RV/16-1:0]   m_addr,
    output logic [RV-1:0]         m_wdata,
    output logic [RV/8-1:0]       m_wmask,
    output logic                  m_io,
    input  logic                  m_ack,
    input  logic [RV-1:0]         m_rdata,
    output logic [1:0]            owner
);

    // pc holds address bits [VA-1:1]; the word address starts at bit RV/16,
    // which sits at index RV/16-1 of pc.
    localparam int          PC_LSB     = RV/16 - 1;
    localparam logic [3:0]  STARVE_MAX = 4'(DMA_STARVE);

    localparam logic [1:0]  OWN_NONE  = 2'd0;
    localparam logic [1:0]  OWN_DATA  = 2'd1;
    localparam logic [1:0]  OWN_FETCH = 2'd2;
    localparam logic [1:0]  OWN_DMA   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       data_req;
    logic       dma_force;
    logic       dma_win;

    // The low pc bits below the word address are consumed by the core, not here.
    logic       unused_pc;
    assign unused_pc = ^pc;

    always_comb begin
        data_req  = (|wmask) || (|rstrobe);
        dma_force = dma_req && (starve_cnt == STARVE_MAX);
        // DMA wins when forced, or when nobody from the core is asking.
        dma_win   = dma_force || (dma_req && !data_req && !ifetch);
    end

    // NOTE: every register, including rdata, is reset so a beat cut short by
    // reset cannot leave stale bus controls or read data visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wmask    <= '0;
            m_io       <= 1'b0;
            idone      <= 1'b0;
            rdone      <= 1'b0;
            wdone      <= 1'b0;
            dma_done   <= 1'b0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dma_win) begin
                        owner      <= OWN_DMA;
                        m_req      <= 1'b1;
                        m_we       <= dma_we;
                        m_addr     <= dma_addr;
                        m_wdata    <= dma_wdata;
                        m_wmask    <= dma_we ? dma_wmask : '0;
                        m_io       <= 1'b0;
                        starve_cnt <= 4'd0;
                        state      <= BUSY;
                    end else if (data_req || ifetch) begin
                        if (data_req) begin
                            // A nonzero mask makes it a write even if rstrobe is also set.
                            owner   <= OWN_DATA;
                            m_we    <= |wmask;
                            m_addr  <= addr;
                            m_wdata <= wdata;
                            m_wmask <= wmask;
                            m_io    <= io_access;
                        end else begin
                            // Fetch reads the whole word; the core picks the halfword.
                            owner   <= OWN_FETCH;
                            m_we    <= 1'b0;
                            m_addr  <= pc[VA-2:PC_LSB];
                            m_wdata <= '0;
                            m_wmask <= '0;
                            m_io    <= 1'b0;
                        end
                        m_req <= 1'b1;
                        state <= BUSY;
                        if (!dma_req) begin
                            starve_cnt <= 4'd0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else begin
                        // No request at all implies dma_req is low.
                        starve_cnt <= 4'd0;
                    end
                end

                BUSY: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        if (!m_we) begin
                            rdata <= m_rdata;
                        end
                        idone    <= (owner == OWN_FETCH);
                        rdone    <= (owner == OWN_DATA) && !m_we;
                        wdone    <= (owner == OWN_DATA) && m_we;
                        dma_done <= (owner == OWN_DMA);
                        state    <= DONE;
                    end
                end

                DONE: begin
                    // One cycle with no arbitration lets the requester drop its level.
                    idone    <= 1'b0;
                    rdone    <= 1'b0;
                    wdone    <= 1'b0;
                    dma_done <= 1'b0;
                    owner    <= OWN_NONE;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
